// File: rtl/apb_gpio_v2.sv
// APB GPIO controller: direction/output registers with atomic set/clear/toggle,
// per-pin debounced inputs, level/edge interrupts with sticky W1C status.
module apb_gpio_v2 #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_GPIO       = 32,
   parameter int PADCFG_BITS    = 5,
   parameter int DEB_WIDTH      = 8
) (
   input  logic                            HCLK,
   input  logic                            HRESET,
   input  logic [APB_ADDR_WIDTH-1:0]       PADDR,
   input  logic [31:0]                     PWDATA,
   input  logic                            PWRITE,
   input  logic                            PSEL,
   input  logic                            PENABLE,
   output logic [31:0]                     PRDATA,
   output logic                            PREADY,
   output logic                            PSLVERR,
   input  logic [NUM_GPIO-1:0]             gpio_in,
   output logic [NUM_GPIO-1:0]             gpio_out,
   output logic [NUM_GPIO-1:0]             gpio_dir,
   output logic [NUM_GPIO*PADCFG_BITS-1:0] gpio_padcfg,
   output logic                            interrupt
);

   localparam logic [4:0] R_DIR = 5'd0,  R_IN = 5'd1,  R_OUT = 5'd2,  R_INTEN = 5'd3;
   localparam logic [4:0] R_TYPE0 = 5'd4, R_TYPE1 = 5'd5, R_STATUS = 5'd6, R_SET = 5'd7;
   localparam logic [4:0] R_CLR = 5'd8, R_TGL = 5'd9, R_DEBEN = 5'd10, R_DEBCNT = 5'd11;
   localparam int         PAD_BASE = 16;
   localparam logic [DEB_WIDTH-1:0] CNT_ONE = 1;

   logic [4:0]                idx;
   logic                      mapped;
   logic                      wr;
   logic [NUM_GPIO-1:0]       wdata;
   logic                      unused_bits;

   logic [NUM_GPIO-1:0]       dir_q, out_q, inten_q, type0_q, type1_q, status_q, deben_q;
   logic [DEB_WIDTH-1:0]      debcnt_q;
   logic [NUM_GPIO-1:0]       padcfg_q [PADCFG_BITS];
   logic [NUM_GPIO-1:0]       sync_p0, sync_p1, in_f_p2, in_q_p3;
   logic [DEB_WIDTH-1:0]      cnt [NUM_GPIO];
   logic [NUM_GPIO-1:0]       filt_on;
   logic [NUM_GPIO-1:0]       event_hit;
   logic [NUM_GPIO-1:0]       clr_mask;

   function automatic logic [31:0] ext(input logic [NUM_GPIO-1:0] v);
      ext = '0;
      ext[NUM_GPIO-1:0] = v;
   endfunction

   assign idx         = PADDR[6:2];
   assign wdata       = PWDATA[NUM_GPIO-1:0];
   assign unused_bits = ^{PADDR, PWDATA};
   assign mapped      = (idx <= R_DEBCNT) ||
                        (int'(idx) >= PAD_BASE && int'(idx) < PAD_BASE + PADCFG_BITS);
   assign wr          = PSEL & PENABLE & PWRITE & mapped;
   assign PREADY      = 1'b1;
   assign PSLVERR     = PSEL & PENABLE & ~mapped;
   assign gpio_out    = out_q;
   assign gpio_dir    = dir_q;
   assign interrupt   = |status_q;
   assign filt_on     = deben_q & {NUM_GPIO{debcnt_q != '0}};
   assign clr_mask    = (wr && idx == R_STATUS) ? wdata : '0;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dir_q    <= '0;
         out_q    <= '0;
         inten_q  <= '0;
         type0_q  <= '0;
         type1_q  <= '0;
         deben_q  <= '0;
         debcnt_q <= '0;
         for (int k = 0; k < PADCFG_BITS; k++) padcfg_q[k] <= '0;
      end else if (wr) begin
         case (idx)
            R_DIR:    dir_q    <= wdata;
            R_OUT:    out_q    <= wdata;
            R_INTEN:  inten_q  <= wdata;
            R_TYPE0:  type0_q  <= wdata;
            R_TYPE1:  type1_q  <= wdata;
            R_SET:    out_q    <= out_q | wdata;
            R_CLR:    out_q    <= out_q & ~wdata;
            R_TGL:    out_q    <= out_q ^ wdata;
            R_DEBEN:  deben_q  <= wdata;
            R_DEBCNT: debcnt_q <= PWDATA[DEB_WIDTH-1:0];
            default: begin
               for (int k = 0; k < PADCFG_BITS; k++)
                  if (int'(idx) == PAD_BASE + k) padcfg_q[k] <= wdata;
            end
         endcase
      end
   end

   // Input stage: two-flop synchroniser, debounce filter, edge-detect delay
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         in_f_p2 <= '0;
         in_q_p3 <= '0;
         for (int i = 0; i < NUM_GPIO; i++) cnt[i] <= '0;
      end else begin
         sync_p0 <= gpio_in;
         sync_p1 <= sync_p0;
         in_q_p3 <= in_f_p2;
         for (int i = 0; i < NUM_GPIO; i++) begin
            if (!filt_on[i]) begin
               in_f_p2[i] <= sync_p1[i];
               cnt[i]     <= '0;
            end else if (sync_p1[i] == in_f_p2[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] >= debcnt_q) begin
               // >= keeps a pin from stalling if DEBCNT is lowered mid-count;
               // it also means cnt never exceeds DEBCNT, so it cannot wrap.
               in_f_p2[i] <= sync_p1[i];
               cnt[i]     <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      event_hit = '0;
      for (int i = 0; i < NUM_GPIO; i++) begin
         case ({type1_q[i], type0_q[i]})
            2'b00:   event_hit[i] = in_f_p2[i];
            2'b01:   event_hit[i] = ~in_f_p2[i];
            2'b10:   event_hit[i] = in_f_p2[i] & ~in_q_p3[i];
            default: event_hit[i] = in_f_p2[i] ^ in_q_p3[i];
         endcase
      end
   end

   // Status stage: a new event in the same cycle as a W1C keeps the bit set
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) status_q <= '0;
      else        status_q <= (status_q & ~clr_mask) | (event_hit & inten_q);
   end

   always_comb begin
      PRDATA = '0;
      case (idx)
         R_DIR:    PRDATA = ext(dir_q);
         R_IN:     PRDATA = ext(in_f_p2);
         R_OUT:    PRDATA = ext(out_q);
         R_INTEN:  PRDATA = ext(inten_q);
         R_TYPE0:  PRDATA = ext(type0_q);
         R_TYPE1:  PRDATA = ext(type1_q);
         R_STATUS: PRDATA = ext(status_q);
         R_DEBEN:  PRDATA = ext(deben_q);
         R_DEBCNT: PRDATA[DEB_WIDTH-1:0] = debcnt_q;
         default: begin
            for (int k = 0; k < PADCFG_BITS; k++)
               if (int'(idx) == PAD_BASE + k) PRDATA = ext(padcfg_q[k]);
         end
      endcase
   end

   always_comb begin
      gpio_padcfg = '0;
      for (int i = 0; i < NUM_GPIO; i++)
         for (int k = 0; k < PADCFG_BITS; k++)
            gpio_padcfg[i*PADCFG_BITS + k] = padcfg_q[k][i];
   end

endmodule

// File: tb/tb_apb_gpio_v2.sv
// Bench for apb_gpio_v2: directed scenarios plus random APB/pin traffic against
// a behavioural model; a second small instance covers the reduced-parameter map.
module tb_apb_gpio_v2;

   localparam int NG = 32;
   localparam int PB = 5;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE, PENABLE, psel_a, psel_b;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;
   logic [31:0] gin_a, gout_a, gdir_a;
   logic [159:0] gpad_a;
   logic        irq_a;
   logic [7:0]  gin_b, gout_b, gdir_b;
   logic [15:0] gpad_b;
   logic        irq_b;

   always #5 HCLK = ~HCLK;

   apb_gpio_v2 dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(psel_a), .PENABLE(PENABLE), .PRDATA(prdata_a), .PREADY(pready_a),
      .PSLVERR(pslverr_a), .gpio_in(gin_a), .gpio_out(gout_a), .gpio_dir(gdir_a),
      .gpio_padcfg(gpad_a), .interrupt(irq_a));

   apb_gpio_v2 #(.NUM_GPIO(8), .PADCFG_BITS(2)) dut_b (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(psel_b), .PENABLE(PENABLE), .PRDATA(prdata_b), .PREADY(pready_b),
      .PSLVERR(pslverr_b), .gpio_in(gin_b), .gpio_out(gout_b), .gpio_dir(gdir_b),
      .gpio_padcfg(gpad_b), .interrupt(irq_b));

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of instance A ----------------
   logic [31:0] m_dir, m_out, m_inten, m_t0, m_t1, m_stat, m_deben;
   logic [7:0]  m_debcnt;
   logic [31:0] m_pad [PB];
   logic [31:0] m_s0, m_s1, m_f, m_q;
   int          m_run [NG];
   logic [31:0] t_ev, t_stat, t_f;
   int          t_idx;

   function automatic bit amap(input int idx);
      return idx <= 11 || (idx >= 16 && idx < 16 + PB);
   endfunction

   function automatic logic [31:0] mread(input int idx);
      case (idx)
         0: return m_dir;
         1: return m_f;
         2: return m_out;
         3: return m_inten;
         4: return m_t0;
         5: return m_t1;
         6: return m_stat;
         10: return m_deben;
         11: return {24'd0, m_debcnt};
         default: return (idx >= 16 && idx < 16 + PB) ? m_pad[idx-16] : 32'd0;
      endcase
   endfunction

   function automatic logic [159:0] mpad_flat();
      logic [159:0] r = '0;
      for (int i = 0; i < NG; i++)
         for (int k = 0; k < PB; k++) r[i*PB + k] = m_pad[k][i];
      return r;
   endfunction

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         {m_dir, m_out, m_inten, m_t0, m_t1, m_stat, m_deben} = '0;
         m_debcnt = '0;
         {m_s0, m_s1, m_f, m_q} = '0;
         for (int k = 0; k < PB; k++) m_pad[k] = '0;
         for (int i = 0; i < NG; i++) m_run[i] = 0;
      end else begin
         t_idx = int'(PADDR[6:2]);
         for (int i = 0; i < NG; i++) begin
            // level high, level low, rising, either edge
            if (!m_t1[i]) t_ev[i] = m_t0[i] ? !m_f[i] : m_f[i];
            else          t_ev[i] = m_t0[i] ? (m_f[i] != m_q[i]) : (m_f[i] && !m_q[i]);
         end
         t_stat = m_stat;
         if (psel_a && PENABLE && PWRITE && t_idx == 6) t_stat = t_stat & ~PWDATA;
         t_stat = t_stat | (t_ev & m_inten);
         t_f = m_f;
         for (int i = 0; i < NG; i++) begin
            if (!m_deben[i] || m_debcnt == 0) begin
               t_f[i] = m_s1[i];
               m_run[i] = 0;
            end else if (m_s1[i] == m_f[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i] = m_run[i] + 1;          // samples in the current differing run
               if (m_run[i] >= int'(m_debcnt) + 1) begin
                  t_f[i] = m_s1[i];
                  m_run[i] = 0;
               end
            end
         end
         m_q = m_f;  m_f = t_f;  m_s1 = m_s0;  m_s0 = gin_a;  m_stat = t_stat;
         if (psel_a && PENABLE && PWRITE) begin
            case (t_idx)
               0: m_dir = PWDATA;
               2: m_out = PWDATA;
               3: m_inten = PWDATA;
               4: m_t0 = PWDATA;
               5: m_t1 = PWDATA;
               7: m_out = m_out | PWDATA;
               8: m_out = m_out & ~PWDATA;
               9: m_out = m_out ^ PWDATA;
               10: m_deben = PWDATA;
               11: m_debcnt = PWDATA[7:0];
               default: if (t_idx >= 16 && t_idx < 16 + PB) m_pad[t_idx-16] = PWDATA;
            endcase
         end
      end
   end

   // Continuous output comparison
   always @(posedge HCLK) begin
      #1;
      if (chk_en && !HRESET) begin
         check("gpio_out", gout_a, m_out);
         check("gpio_dir", gdir_a, m_dir);
         check("interrupt", irq_a, |m_stat);
         check("gpio_padcfg", gpad_a, mpad_flat());
      end
   end

   // ---------------- APB driver ----------------
   task automatic xfer(input bit b, input bit w, input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
      @(negedge HCLK);
      psel_a = !b;  psel_b = b;  PENABLE = 1'b0;  PWRITE = w;  PADDR = a;  PWDATA = wd;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1;
      rd  = b ? prdata_b : prdata_a;
      err = b ? pslverr_b : pslverr_a;
      if (!b) begin
         check("pslverr", err, !amap(int'(a[6:2])));
         if (!w) check("prdata", rd, mread(int'(a[6:2])));
      end
      @(negedge HCLK);
      psel_a = 1'b0;  psel_b = 1'b0;  PENABLE = 1'b0;  PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] wd);
      logic [31:0] d;
      logic e;
      xfer(1'b0, 1'b1, a, wd, d, e);
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      logic e;
      xfer(1'b0, 1'b0, a, 32'd0, d, e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic e;
      int idx;

      HRESET = 1'b1;  PADDR = '0;  PWDATA = '0;  PWRITE = 1'b0;  PENABLE = 1'b0;
      psel_a = 1'b0;  psel_b = 1'b0;  gin_a = '0;  gin_b = '0;
      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;
      chk_en = 1'b1;
      #1;
      check("rst_gpio_out", gout_a, 0);
      check("rst_gpio_dir", gdir_a, 0);
      check("rst_padcfg", gpad_a, 0);
      check("rst_irq", irq_a, 0);
      check("rst_pslverr", pslverr_a, 0);
      check("pready", pready_a, 1);

      // Unmapped 0x30 read/write, then every mapped offset reads 0
      xfer(1'b0, 1'b0, 12'h030, 32'd0, d, e);
      check("unmapped_rd_err", e, 1);
      check("unmapped_rd_data", d, 0);
      xfer(1'b0, 1'b1, 12'h030, 32'hFFFF_FFFF, d, e);
      check("unmapped_wr_err", e, 1);
      for (int i = 0; i < 32; i++) begin
         if (amap(i)) begin
            rd(12'(i * 4), d);
            check("reset_read", d, 0);
         end
      end

      // Atomic output ops
      wr(12'h008, 32'h0000_00F0);
      wr(12'h01C, 32'h1);
      check("outset", gout_a, 32'h0F1);
      wr(12'h020, 32'h10);
      check("outclr", gout_a, 32'h0E1);
      wr(12'h024, 32'h300);
      check("outtgl", gout_a, 32'h3E1);
      rd(12'h008, d);
      check("out_read", d, 32'h0000_03E1);
      rd(12'h01C, d);
      check("outset_reads0", d, 0);

      // Rising-edge interrupt on pin 3
      wr(12'h014, 32'h8);
      wr(12'h00C, 32'h8);
      gin_a[3] = 1'b1;
      repeat (3) @(posedge HCLK);
      #1 check("rise_irq_e3", irq_a, 0);
      @(posedge HCLK);
      #1 check("rise_irq_e4", irq_a, 1);
      rd(12'h018, d);
      check("rise_status", d, 32'h8);
      wr(12'h018, 32'h8);
      check("w1c_irq", irq_a, 0);
      gin_a[3] = 1'b0;
      repeat (8) @(posedge HCLK);
      #1 check("fall_no_irq", irq_a, 0);

      // Both-edges on pin 0; W1C collides with the falling-edge set
      wr(12'h00C, 32'h0);
      wr(12'h014, 32'h1);
      wr(12'h010, 32'h1);
      wr(12'h018, 32'hFFFF_FFFF);
      wr(12'h00C, 32'h1);
      gin_a[0] = 1'b1;
      repeat (4) @(posedge HCLK);
      #1 check("both_rise_irq", irq_a, 1);
      wr(12'h018, 32'h1);
      check("both_cleared", irq_a, 0);
      gin_a[0] = 1'b0;
      @(negedge HCLK);
      wr(12'h018, 32'h1);
      check("set_wins_irq", irq_a, 1);
      rd(12'h018, d);
      check("set_wins_status", d, 32'h1);

      // Debounce on pin 5, DEBCNT=4
      wr(12'h00C, 32'h0);
      wr(12'h018, 32'hFFFF_FFFF);
      wr(12'h028, 32'h20);
      wr(12'h02C, 32'h4);
      gin_a[5] = 1'b1;
      repeat (3) @(negedge HCLK);
      gin_a[5] = 1'b0;
      repeat (10) @(negedge HCLK);
      rd(12'h004, d);
      check("glitch_in5", d[5], 0);
      psel_a = 1'b1;  PENABLE = 1'b0;  PWRITE = 1'b0;  PADDR = 12'h004;
      @(negedge HCLK);
      PENABLE = 1'b1;
      gin_a[5] = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge HCLK);
         #1;
         check("deb_in5", prdata_a[5], c >= 7);
         check("deb_model", prdata_a, mread(1));
      end
      repeat (3) @(negedge HCLK);
      gin_a[5] = 1'b0;
      psel_a = 1'b0;  PENABLE = 1'b0;
      repeat (8) @(negedge HCLK);

      // Random traffic
      for (int it = 0; it < 600; it++) begin
         case ($urandom_range(0, 9))
            0, 1: begin
               @(negedge HCLK);
               gin_a = gin_a ^ (32'd1 << $urandom_range(0, 31)) ^ (32'd1 << $urandom_range(0, 31));
            end
            2, 3, 4, 5: begin
               idx = $urandom_range(0, 31);
               d = $urandom;
               if (idx == 11) d = d & 32'h7;
               wr(12'(idx * 4), d);
            end
            default: begin
               idx = $urandom_range(0, 31);
               rd(12'(idx * 4), d);
            end
         endcase
      end

      // Reset in the middle of a write access
      @(negedge HCLK);
      psel_a = 1'b1;  PENABLE = 1'b0;  PWRITE = 1'b1;  PADDR = 12'h008;  PWDATA = 32'hA5A5;
      @(negedge HCLK);
      PENABLE = 1'b1;
      HRESET = 1'b1;
      #1 check("rst_mid_prdata", prdata_a, 0);
      @(negedge HCLK);
      psel_a = 1'b0;  PENABLE = 1'b0;  PWRITE = 1'b0;  PADDR = '0;
      #1 check("rst_dir_prdata", prdata_a, 0);
      HRESET = 1'b0;
      @(negedge HCLK);
      check("rst_mid_out", gout_a, 0);
      check("rst_mid_irq", irq_a, 0);
      rd(12'h008, d);
      check("rst_mid_out_read", d, 0);

      // Reduced instance: 8 pins, 2 pad-config bits
      xfer(1'b1, 1'b1, 12'h044, 32'hFFFF_FF81, d, e);
      check("b_pad1_wr_err", e, 0);
      xfer(1'b1, 1'b0, 12'h044, 32'd0, d, e);
      check("b_pad1_read", d, 32'h81);
      check("b_padcfg_port", gpad_b, 16'h8002);
      xfer(1'b1, 1'b0, 12'h048, 32'd0, d, e);
      check("b_pad2_err", e, 1);
      check("b_pad2_data", d, 0);
      xfer(1'b1, 1'b1, 12'h000, 32'hFFFF_FFFF, d, e);
      xfer(1'b1, 1'b0, 12'h000, 32'd0, d, e);
      check("b_dir_read", d, 32'hFF);
      check("b_dir_port", gdir_b, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
